// File: rtl/controller_pkg.sv
// Shared controller definitions: FSM state encoding, instruction field constants
// and datapath mux select codes (also consumed by the ALU controller).
package controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EX      = 4'd6,
    S_R_WB      = 4'd7,
    S_I_EX      = 4'd8,
    S_I_WB      = 4'd9,
    S_BRANCH    = 4'd10,
    S_JUMP      = 4'd11,
    S_JR        = 4'd12,
    S_HALT      = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_J      = 6'b000010;
  localparam logic [5:0] OP_JAL    = 6'b000011;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDIU  = 6'b001001;
  localparam logic [5:0] OP_ANDI   = 6'b001100;
  localparam logic [5:0] OP_ORI    = 6'b001101;
  localparam logic [5:0] OP_XORI   = 6'b001110;
  localparam logic [5:0] OP_COP0   = 6'b010000;
  localparam logic [5:0] OP_LW     = 6'b100011;
  localparam logic [5:0] OP_SW     = 6'b101011;
  localparam logic [5:0] OP_HALT   = 6'b111111;

  localparam logic [5:0] FN_JR     = 6'b001000;
  localparam logic [5:0] FN_MULT   = 6'b011000;
  localparam logic [5:0] FN_MULTU  = 6'b011001;

  localparam logic [1:0] ALU_OP_ADD  = 2'b00;
  localparam logic [1:0] ALU_OP_FUNC = 2'b10;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_BROFF = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier: next state out of DECODE and R_EX,
// signed-immediate flag and illegal-opcode flag.
module ctrl_decode
  import controller_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output state_t     o_decode_next,
  output state_t     o_rex_next,
  output logic       o_is_signed,
  output logic       o_illegal
);

  always_comb begin
    o_decode_next = S_HALT;
    o_illegal     = 1'b0;
    case (i_opcode)
      OP_RTYPE:                                   o_decode_next = S_R_EX;
      OP_LW, OP_SW:                               o_decode_next = S_MEM_ADDR;
      OP_ADDIU, OP_COP0, OP_ANDI, OP_ORI, OP_XORI: o_decode_next = S_I_EX;
      OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: o_decode_next = S_BRANCH;
      OP_J, OP_JAL:                               o_decode_next = S_JUMP;
      OP_HALT:                                    o_decode_next = S_HALT;
      default:                                    o_illegal     = 1'b1;
    endcase
  end

  // MULT/MULTU write HI/LO inside the ALU, so they skip register writeback
  always_comb begin
    case (i_funct)
      FN_JR:              o_rex_next = S_JR;
      FN_MULT, FN_MULTU:  o_rex_next = S_FETCH;
      default:            o_rex_next = S_R_WB;
    endcase
  end

  assign o_is_signed = (i_opcode == OP_ADDIU) || (i_opcode == OP_COP0);

endmodule

// File: rtl/main_controller.sv
// Multicycle main control FSM: state register and per-state output decode;
// instruction classification is delegated to ctrl_decode.
module main_controller
  import controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic       jump_and_link,
  output logic       is_signed,
  output logic       illegal,
  output logic [1:0] pc_source,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op
);

  state_t r_state;
  state_t w_next;
  state_t w_decode_next;
  state_t w_rex_next;
  logic   w_dec_signed;
  logic   w_dec_illegal;
  logic   r_run;
  logic   r_illegal;
  logic   r_is_store;
  logic   r_is_jal;

  ctrl_decode u_decode (
    .i_opcode      (opcode),
    .i_funct       (funct),
    .o_decode_next (w_decode_next),
    .o_rex_next    (w_rex_next),
    .o_is_signed   (w_dec_signed),
    .o_illegal     (w_dec_illegal)
  );

  // r_run holds outputs quiet until the first edge after reset release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_run      <= 1'b0;
      r_illegal  <= 1'b0;
      r_is_store <= 1'b0;
      r_is_jal   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (r_run) begin
        r_state <= w_next;
        if (r_state == S_DECODE) begin
          r_is_store <= (opcode == OP_SW);
          r_is_jal   <= (opcode == OP_JAL);
          if (w_dec_illegal) r_illegal <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:     if (mem_ready) w_next = S_DECODE;
      S_DECODE:    w_next = w_decode_next;
      S_MEM_ADDR:  w_next = r_is_store ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) w_next = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) w_next = S_FETCH;
      S_R_EX:      w_next = w_rex_next;
      S_I_EX:      w_next = S_I_WB;
      S_HALT:      w_next = S_HALT;
      default:     w_next = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    alu_src_a     = 1'b0;
    jump_and_link = 1'b0;
    pc_source     = PCSRC_ALU;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_OP_ADD;
    is_signed     = r_run & w_dec_signed;
    illegal       = r_illegal;
    if (r_run) begin
      case (r_state)
        S_FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE:   alu_src_b = SRCB_BROFF;
        S_MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEM_READ: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write = 1'b1;
          i_or_d    = 1'b1;
        end
        S_R_EX: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_OP_FUNC;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_I_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
          alu_op    = ALU_OP_FUNC;
        end
        S_I_WB:     reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = ALU_OP_FUNC;
          pc_write_cond = 1'b1;
          pc_source     = PCSRC_ALUOUT;
        end
        S_JUMP: begin
          pc_write      = 1'b1;
          pc_source     = PCSRC_JUMP;
          jump_and_link = r_is_jal;
          reg_write     = r_is_jal;
        end
        S_JR: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_OP_FUNC;
          pc_write  = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
